ex_mem_elastic_stage: RTL and testbench
=======================================

Name: ex_mem_elastic_stage

Overview:
Elastic EX→MEM pipeline stage that replaces the fixed EX/MEM register with a valid/ready-handshaked, 2-entry (main + skid) buffer.
- Carries parametrised counts of scalar and vector result channels plus a control-flag vector.
- Adds backpressure, flush and output-enable gating that the fixed register lacks.
- Sits between the scalar/vector ALU+swap units and the memory/writeback stage.

Parameters:
REGI_SIZE, 16, scalar result width (bits)
ELEM_SIZE, 8, vector element width (bits)
VECT_SIZE, 8, elements per vector
SCAL_CH, 2, number of scalar result channels (ialu, iswa by default)
VECT_CH, 2, number of vector result channels (valu, vswa by default)
CTRL_BITS, 5, control flag count; bit0 enableMem, 1 enableReg, 2 enableJump, 3 flagMemRead, 4 flagMemWrite

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset (asserted at 0)
flush_i  in  1  synchronous kill of all buffered entries
valid_i  in  1  upstream entry valid
ready_o  out  1  stage can accept an entry
scal_res_i  in  SCAL_CH*REGI_SIZE  packed scalar results, channel 0 in LSBs
vect_res_i  in  VECT_CH*VECT_SIZE*ELEM_SIZE  packed vector results, channel 0 in LSBs
ctrl_i  in  CTRL_BITS  control flags
valid_o  out  1  output entry valid
ready_i  in  1  downstream accepts
scal_res_o  out  SCAL_CH*REGI_SIZE  buffered scalar results
vect_res_o  out  VECT_CH*VECT_SIZE*ELEM_SIZE  buffered vector results
ctrl_o  out  CTRL_BITS  control flags, gated by valid_o
stall_cnt_o  out  16  backpressure cycle count (only with EPIPE_STATS_EN)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_i.
- Reset: main_v=0 and skid_v=0; all payload registers=0. valid_o=0, ctrl_o=0, scal_res_o=0, vect_res_o=0. ready_o=1 (ready_o = !skid_v, combinational). stall_cnt_o=0.
- Handshakes: accept = valid_i & ready_o; drain = valid_o & ready_i.
- Upstream rule: valid_i must not depend on ready_o.
- Output stability: while valid_o & !ready_i, all outputs are held stable.
- Outputs always come from the main entry: valid_o = main_v.
- ctrl_o = main_v ? main.ctrl : 0. Downstream never sees an enable without valid.
- Latency and throughput: 1 cycle input→output with no backpressure; sustained throughput 1 entry/cycle.
- Transitions, evaluated at the clock edge (flush has priority over all of them):
  - Main empty or draining, skid empty: an accepted input loads main.
  - Main full, not draining, accept: input loads skid. ready_o falls in the next cycle.
  - Main draining, skid full: skid moves to main, skid_v clears, ready_o rises in the next cycle. ready_o=0 in that cycle, so no accept can occur.
  - No accept and drain with skid empty: main_v clears.
- Ordering: strict FIFO order; an entry is never lost or duplicated.
- flush_i=1: next cycle main_v=0 and skid_v=0.
  - An input accepted in the flush cycle is discarded.
  - Payload registers are not cleared; ctrl_o=0 through gating.
  - A drain in the flush cycle still counts as completed downstream.
- Simultaneous flush_i and rst_i low: reset wins.
- rst_i low mid-operation: both entries dropped immediately (asynchronously); outputs take their reset values.
- No arithmetic on the payload; widths pass through unchanged.

Optional Feature:
- Macro: EPIPE_STATS_EN.
- Defined: stall_cnt_o increments by 1 each cycle where valid_o & !ready_i.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the stall_cnt_o port and the counter are absent.

Decomposition:
- Package epipe_pkg:
  - ctrl bit-index constants: CTRL_MEM_EN, CTRL_REG_EN, CTRL_JMP_EN, CTRL_MEM_RD, CTRL_MEM_WR.
  - Default width localparams.
  - Packed struct epipe_payload_t {scal, vect, ctrl}.
- Sub-module pipe_skid_buf: a generic WIDTH-parametrised main+skid buffer with valid/ready and flush. The top packs the payload into it and applies ctrl gating and the optional counter.

Test Plan:
- Reset then streaming: release rst_i, ready_i=1, drive 4 entries with scal_res_i=16'h0001..16'h0004 on consecutive cycles → valid_o high one cycle after each accept, same values in order, ready_o stays 1.
- Backpressure fills skid: ready_i=0, send A=16'hAAAA then B=16'hBBBB → valid_o=1 holding A, ready_o=0 after B. Set ready_i=1 → A then B appear on consecutive cycles, ready_o returns to 1.
- Flush: main=A and skid=B, assert flush_i with valid_i=1 carrying C → next cycle valid_o=0, ctrl_o=0, ready_o=1, and C never appears.
- Ctrl gating: ctrl_i=5'b10001 accepted then drained with no new input → ctrl_o=5'b10001 for one cycle, then 0 while valid_o=0.
- Async reset mid-stall: both entries full and rst_i driven low between clock edges → valid_o=0, ctrl_o=0, ready_o=1 immediately, without waiting for a clock edge.
- EPIPE_STATS_EN: hold valid_o=1 with ready_i=0 for 10 cycles → stall_cnt_o=10. Preload near 16'hFFFF → saturates, no wrap.

Source files
------------

// File: rtl/epipe_pkg.sv
// Shared types and constants for the elastic EX->MEM stage.
// Default widths, control flag indices and the payload layout.
package epipe_pkg;

    localparam int REGI_SIZE_D = 16;
    localparam int ELEM_SIZE_D = 8;
    localparam int VECT_SIZE_D = 8;
    localparam int SCAL_CH_D   = 2;
    localparam int VECT_CH_D   = 2;
    localparam int CTRL_BITS_D = 5;

    localparam int CTRL_MEM_EN = 0;
    localparam int CTRL_REG_EN = 1;
    localparam int CTRL_JMP_EN = 2;
    localparam int CTRL_MEM_RD = 3;
    localparam int CTRL_MEM_WR = 4;

    // Payload order matches the flat bus packed by the stage: scal | vect | ctrl
    typedef struct packed {
        logic [SCAL_CH_D*REGI_SIZE_D-1:0]             scal;
        logic [VECT_CH_D*VECT_SIZE_D*ELEM_SIZE_D-1:0] vect;
        logic [CTRL_BITS_D-1:0]                       ctrl;
    } epipe_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic main+skid elastic buffer with valid/ready and flush.
// Output always comes from the main entry; skid absorbs one stalled beat.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    logic             r_main_v;
    logic             r_skid_v;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_drain;

    assign ready_o  = ~r_skid_v;
    assign valid_o  = r_main_v;
    assign data_o   = r_main;
    assign w_accept = valid_i & ~r_skid_v;
    assign w_drain  = r_main_v & ready_i;

    // Entry valid flags: flush kills both, otherwise FIFO move/load/clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (flush_i) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (r_skid_v) begin
            if (w_drain) begin
                r_skid_v <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_main_v && !w_drain) begin
                r_skid_v <= 1'b1;
            end else begin
                r_main_v <= 1'b1;
            end
        end else if (w_drain) begin
            r_main_v <= 1'b0;
        end
    end

    // Payload registers: follow the valid moves, untouched by flush
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (!flush_i) begin
            if (r_skid_v) begin
                if (w_drain) begin
                    r_main <= r_skid;
                end
            end else if (w_accept) begin
                if (r_main_v && !w_drain) begin
                    r_skid <= data_i;
                end else begin
                    r_main <= data_i;
                end
            end
        end
    end

endmodule

// File: rtl/ex_mem_elastic_stage.sv
// Elastic EX->MEM stage: packs results into a main+skid buffer, gates ctrl.
// Optional stall counter enabled by the EPIPE_STATS_EN macro.
module ex_mem_elastic_stage
    import epipe_pkg::*;
#(
    parameter int REGI_SIZE = REGI_SIZE_D,
    parameter int ELEM_SIZE = ELEM_SIZE_D,
    parameter int VECT_SIZE = VECT_SIZE_D,
    parameter int SCAL_CH   = SCAL_CH_D,
    parameter int VECT_CH   = VECT_CH_D,
    parameter int CTRL_BITS = CTRL_BITS_D
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [SCAL_CH*REGI_SIZE-1:0]         scal_res_i,
    input  logic [VECT_CH*VECT_SIZE*ELEM_SIZE-1:0] vect_res_i,
    input  logic [CTRL_BITS-1:0]                 ctrl_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [SCAL_CH*REGI_SIZE-1:0]         scal_res_o,
    output logic [VECT_CH*VECT_SIZE*ELEM_SIZE-1:0] vect_res_o,
`ifdef EPIPE_STATS_EN
    output logic [CTRL_BITS-1:0]                 ctrl_o,
    output logic [15:0]                          stall_cnt_o
`else
    output logic [CTRL_BITS-1:0]                 ctrl_o
`endif
);

    localparam int SW = SCAL_CH * REGI_SIZE;
    localparam int VW = VECT_CH * VECT_SIZE * ELEM_SIZE;
    localparam int PW = SW + VW + CTRL_BITS;

    logic [PW-1:0] w_in;
    logic [PW-1:0] w_out;
    logic          w_valid;

    assign w_in = {scal_res_i, vect_res_i, ctrl_i};

    pipe_skid_buf #(
        .WIDTH (PW)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (w_in),
        .valid_o (w_valid),
        .ready_i (ready_i),
        .data_o  (w_out)
    );

    assign valid_o    = w_valid;
    assign scal_res_o = w_out[PW-1 -: SW];
    assign vect_res_o = w_out[CTRL_BITS +: VW];
    assign ctrl_o     = w_valid ? w_out[CTRL_BITS-1:0] : '0;

`ifdef EPIPE_STATS_EN
    logic [15:0] r_stall_cnt;

    // Count backpressured cycles, saturating; only reset clears it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !ready_i && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_elastic_stage.sv
// Self-checking bench for ex_mem_elastic_stage.
// Compares the DUT against a 2-deep queue model of the elastic stage.
module tb_ex_mem_elastic_stage;

    localparam int SW = 32;
    localparam int VW = 128;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [SW-1:0] scal_res_i = '0;
    logic [VW-1:0] vect_res_i = '0;
    logic [CW-1:0] ctrl_i = '0;
    logic          ready_o;
    logic          valid_o;
    logic [SW-1:0] scal_res_o;
    logic [VW-1:0] vect_res_o;
    logic [CW-1:0] ctrl_o;
`ifdef EPIPE_STATS_EN
    logic [15:0]   stall_cnt_o;
`endif

    always #5 clk = ~clk;

    ex_mem_elastic_stage dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .scal_res_i  (scal_res_i),
        .vect_res_i  (vect_res_i),
        .ctrl_i      (ctrl_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .scal_res_o  (scal_res_o),
        .vect_res_o  (vect_res_o),
`ifdef EPIPE_STATS_EN
        .ctrl_o      (ctrl_o),
        .stall_cnt_o (stall_cnt_o)
`else
        .ctrl_o      (ctrl_o)
`endif
    );

    typedef struct {
        logic [SW-1:0] s;
        logic [VW-1:0] v;
        logic [CW-1:0] c;
    } ent_t;

    ent_t        q[$];
    int unsigned m_stall;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out();
        chk("valid_o", valid_o, q.size() > 0);
        chk("ready_o", ready_o, q.size() < 2);
        if (q.size() > 0) begin
            chk("scal_res_o", scal_res_o, q[0].s);
            chk("vect_res_o", vect_res_o, q[0].v);
            chk("ctrl_o", ctrl_o, q[0].c);
        end else begin
            chk("ctrl_o_gated", ctrl_o, 0);
        end
`ifdef EPIPE_STATS_EN
        chk("stall_cnt_o", stall_cnt_o, m_stall);
`endif
    endtask

    // One clock: drive, check mid-cycle, advance the model at the edge.
    task automatic cyc(input logic v, input logic [SW-1:0] s,
                       input logic [VW-1:0] vec, input logic [CW-1:0] c,
                       input logic r, input logic f);
        bit   acc;
        bit   drn;
        bit   stl;
        ent_t e;
        valid_i    = v;
        scal_res_i = s;
        vect_res_i = vec;
        ctrl_i     = c;
        ready_i    = r;
        flush_i    = f;
        @(negedge clk);
        check_out();
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && r;
        stl = (q.size() > 0) && !r;
        e.s = s;
        e.v = vec;
        e.c = c;
        @(posedge clk);
        if (stl && m_stall < 65535) m_stall++;
        if (f) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    function automatic logic [VW-1:0] rvec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        valid_i = 1'b0;
        flush_i = 1'b0;
        rst_i   = 1'b0;
        q.delete();
        m_stall = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        m_stall = 0;
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 1);
        chk("rst_ctrl_o", ctrl_o, 0);
        chk("rst_scal_o", scal_res_o, 0);
        chk("rst_vect_o", vect_res_o, 0);
`ifdef EPIPE_STATS_EN
        chk("rst_stall", stall_cnt_o, 0);
`endif
        do_reset();

        // streaming, no backpressure
        for (int i = 1; i <= 4; i++)
            cyc(1, 32'(i), rvec(), 5'(i), 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // backpressure fills skid, then drains in order
        cyc(1, 32'hAAAA, rvec(), 5'h01, 0, 0);
        cyc(1, 32'hBBBB, rvec(), 5'h02, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("bp_ready_low", ready_o, 0);
        chk("bp_hold_a", scal_res_o, 32'hAAAA);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);

        // flush with both entries full and C offered
        cyc(1, 32'hAAAA, rvec(), 5'h1F, 0, 0);
        cyc(1, 32'hBBBB, rvec(), 5'h1F, 0, 0);
        cyc(1, 32'hCCCC, rvec(), 5'h1F, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("flush_valid", valid_o, 0);
        chk("flush_ctrl", ctrl_o, 0);
        chk("flush_ready", ready_o, 1);

        // flush discards an input accepted in the same cycle
        cyc(1, 32'hAAAA, rvec(), 5'h03, 0, 0);
        cyc(1, 32'hCCCC, rvec(), 5'h07, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // ctrl gating
        cyc(1, 32'h1234, rvec(), 5'b10001, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, $urandom, rvec(),
                5'($urandom), $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0);

        // async reset mid-stall
        cyc(1, 32'h5555, rvec(), 5'h1F, 0, 0);
        cyc(1, 32'h6666, rvec(), 5'h1F, 0, 0);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_ctrl", ctrl_o, 0);
        chk("arst_ready", ready_o, 1);
        q.delete();
        m_stall = 0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        cyc(0, 0, 0, 0, 1, 0);

`ifdef EPIPE_STATS_EN
        // stall counting and saturation
        cyc(1, 32'h7777, rvec(), 5'h01, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("stall_10", stall_cnt_o, 10);
        cyc(0, 0, 0, 0, 0, 1);
        chk("stall_kept_flush", stall_cnt_o, 11);
        cyc(1, 32'h8888, rvec(), 5'h01, 0, 0);
        for (int i = 0; i < 65530; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("stall_sat", stall_cnt_o, 16'hFFFF);
        cyc(0, 0, 0, 0, 0, 0);
        chk("stall_nowrap", stall_cnt_o, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
